// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream loader for the instruction memory; optional checksum via IMEM_LOADER_CHECKSUM_EN
module imem_boot_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       PC,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CHK   = 3'd7
`endif
  } state_t;

  state_t            state;
  logic [15:0]       load_len;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] load_addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_acc;
`endif

  logic              xfer;
  logic [15:0]       len_next;
  logic [ADDR_W:0]   wc_next;
  logic              last_word;
  logic              unused_pc;

  // Transfer qualifier, candidate length and the end-of-load test used by WRITE
  always_comb begin
    xfer      = byte_valid & byte_ready;
    len_next  = {byte_data, load_len[7:0]};
    wc_next   = word_count + 1'b1;
    last_word = ({{(15 - ADDR_W){1'b0}}, wc_next} == load_len);
    unused_pc = ^{PC[31:ADDR_W+2], PC[1:0]};
  end

  // Memory address mux: the CPU owns the port whenever it is not held
  always_comb begin
    mem_addr = load_addr;
    if (!cpu_hold) begin
      mem_addr = PC[ADDR_W+1:2];
    end
  end

  // Loader FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      load_len   <= '0;
      byte_idx   <= '0;
      load_addr  <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_acc    <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN0;
            word_count <= '0;
            load_addr  <= '0;
            byte_idx   <= '0;
            cpu_hold   <= 1'b1;
            byte_ready <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc    <= '0;
`endif
          end
        end

        S_LEN0: begin
          if (xfer) begin
            load_len[7:0] <= byte_data;
            state         <= S_LEN1;
          end
        end

        S_LEN1: begin
          if (xfer) begin
            load_len[15:8] <= byte_data;
            // Rejecting oversize lengths here keeps the write address inside DEPTH
            if (len_next == 16'd0 || len_next > 16'(DEPTH)) begin
              state      <= S_ERR;
              byte_ready <= 1'b0;
              load_err   <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            case (byte_idx)
              2'd0:    mem_wdata[7:0]   <= byte_data;
              2'd1:    mem_wdata[15:8]  <= byte_data;
              2'd2:    mem_wdata[23:16] <= byte_data;
              default: mem_wdata[31:24] <= byte_data;
            endcase
            byte_idx <= byte_idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc  <= xor_acc ^ byte_data;
`endif
            if (byte_idx == 2'd3) begin
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          load_addr  <= load_addr + 1'b1;
          word_count <= wc_next;
          byte_ready <= 1'b1;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= S_CHK;
`else
            state      <= S_DONE;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b1;
`endif
          end else begin
            state <= S_DATA;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (byte_data == xor_acc) begin
              state     <= S_DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] PC;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [7:0]  word_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] tb_mem [0:127];
  int          wr_cnt = 0;
  int          last_addr = -1;
  logic        mon_en = 1'b0;
  int          rdy_bad = 0;

  imem_boot_loader #(.DEPTH(128), .ADDR_W(7)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .PC         (PC),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 CLK = ~CLK;

  // Instruction memory model: capture every write strobe seen at the clock edge
  always @(posedge CLK) begin
    if (mem_we) begin
      tb_mem[mem_addr] = mem_wdata;
      wr_cnt           = wr_cnt + 1;
      last_addr        = int'(mem_addr);
    end
  end

  // While loading, byte_ready must be low exactly when the write strobe is high
  always @(negedge CLK) begin
    if (mon_en && cpu_hold && !load_err && (byte_ready == mem_we)) begin
      rdy_bad = rdy_bad + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL ready_timeout: byte_ready stayed 0, required 1");
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic send_nominal(input bit rnd);
    send_byte(8'h02, rnd ? int'($urandom_range(0, 3)) : 0);
    send_byte(8'h00, rnd ? int'($urandom_range(0, 3)) : 0);
    send_word(32'hFFFFB037, rnd);
    send_word(32'h00000013, rnd);
  endtask

  // Ends a load: checksum byte when enabled, otherwise the WRITE->DONE cycle
  task automatic finish_load(input logic [7:0] csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum, 0);
`else
    if (csum == 8'hxx) $display("unused");
    tick();
`endif
  endtask

  initial begin
    RST        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    PC         = 32'd8;
    tick();
    tick();

    // Reset state
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_mem_addr_pc", 32'(mem_addr), 32'd2);
    RST = 1'b0;
    tick();

    // Nominal load with cycle-exact write checks
    PC = 32'd0;
    wr_cnt = 0;
    pulse_start();
    chk("nom_hold_after_start", 32'(cpu_hold), 32'd1);
    chk("nom_ready_len0", 32'(byte_ready), 32'd1);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h37, 0);
    send_byte(8'hB0, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    chk("nom_w0_we", 32'(mem_we), 32'd1);
    chk("nom_w0_addr", 32'(mem_addr), 32'd0);
    chk("nom_w0_data", mem_wdata, 32'hFFFFB037);
    chk("nom_w0_ready", 32'(byte_ready), 32'd0);
    send_word(32'h00000013, 1'b0);
    chk("nom_w1_we", 32'(mem_we), 32'd1);
    chk("nom_w1_addr", 32'(mem_addr), 32'd1);
    chk("nom_w1_data", mem_wdata, 32'h00000013);
    finish_load(8'h94);
    chk("nom_done", 32'(load_done), 32'd1);
    chk("nom_hold_released", 32'(cpu_hold), 32'd0);
    chk("nom_word_count", 32'(word_count), 32'd2);
    chk("nom_we_low", 32'(mem_we), 32'd0);
    chk("nom_writes", 32'(wr_cnt), 32'd2);
    chk("nom_mem0", tb_mem[0], 32'hFFFFB037);
    chk("nom_mem1", tb_mem[1], 32'h00000013);
    PC = 32'd4;
    #1;
    chk("nom_pc_mux", 32'(mem_addr), 32'd1);

    // Bad lengths: zero and DEPTH+1, then recovery
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("len0_err", 32'(load_err), 32'd1);
    chk("len0_hold", 32'(cpu_hold), 32'd1);
    chk("len0_ready", 32'(byte_ready), 32'd0);
    pulse_start();
    chk("len129_err_cleared", 32'(load_err), 32'd0);
    send_byte(8'h81, 0);
    send_byte(8'h00, 0);
    chk("len129_err", 32'(load_err), 32'd1);
    tick();
    tick();
    chk("badlen_no_writes", 32'(wr_cnt), 32'd0);
    pulse_start();
    send_nominal(1'b0);
    finish_load(8'h94);
    chk("recover_done", 32'(load_done), 32'd1);
    chk("recover_err_low", 32'(load_err), 32'd0);
    chk("recover_writes", 32'(wr_cnt), 32'd2);

    // Backpressure: random valid gaps must not change the result
    tb_mem[0] = 32'd0;
    tb_mem[1] = 32'd0;
    wr_cnt  = 0;
    rdy_bad = 0;
    mon_en  = 1'b1;
    pulse_start();
    send_nominal(1'b1);
    finish_load(8'h94);
    mon_en = 1'b0;
    chk("gap_done", 32'(load_done), 32'd1);
    chk("gap_word_count", 32'(word_count), 32'd2);
    chk("gap_writes", 32'(wr_cnt), 32'd2);
    chk("gap_mem0", tb_mem[0], 32'hFFFFB037);
    chk("gap_mem1", tb_mem[1], 32'h00000013);
    chk("gap_ready_vs_write", 32'(rdy_bad), 32'd0);

    // Full depth: 128 words, word i = i
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h80, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 128; i++) send_word(32'(i), 1'b0);
    finish_load(8'h00);
    chk("full_writes", 32'(wr_cnt), 32'd128);
    chk("full_last_addr", 32'(last_addr), 32'd127);
    chk("full_mem127", tb_mem[127], 32'd127);
    chk("full_mem64", tb_mem[64], 32'd64);
    chk("full_word_count", 32'(word_count), 32'd128);
    chk("full_done", 32'(load_done), 32'd1);

    // start while in DATA is ignored
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'hFFFFB037, 1'b0);
    tick();
    chk("ign_count_before", 32'(word_count), 32'd1);
    pulse_start();
    chk("ign_count_after", 32'(word_count), 32'd1);
    chk("ign_hold", 32'(cpu_hold), 32'd1);
    send_word(32'h00000013, 1'b0);
    finish_load(8'h94);
    chk("ign_done", 32'(load_done), 32'd1);
    chk("ign_word_count", 32'(word_count), 32'd2);
    chk("ign_mem1", tb_mem[1], 32'h00000013);

    // Reset in the middle of a load
    wr_cnt = 0;
    PC = 32'd12;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'hFFFFB037, 1'b0);
    send_byte(8'h13, 0);
    RST = 1'b1;
    tick();
    chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_ready", 32'(byte_ready), 32'd0);
    chk("mid_rst_count", 32'(word_count), 32'd0);
    chk("mid_rst_mux", 32'(mem_addr), 32'd3);
    RST = 1'b0;
    tick();
    tick();
    chk("mid_rst_writes", 32'(wr_cnt), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte ends in ERR
    pulse_start();
    send_nominal(1'b0);
    send_byte(8'h95, 0);
    chk("csum_bad_err", 32'(load_err), 32'd1);
    chk("csum_bad_done", 32'(load_done), 32'd0);
    chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
